// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin mover between four ingress FIFO lanes and four
// egress FIFO lanes (lane k -> lane k), one pop per cycle, with threshold
// broadcast to all FIFOs and a sticky halt on any FIFO error.
module fifo_rr_arbiter #(
    parameter int unsigned      DATA_W       = 6,
    parameter int unsigned      THR_W        = 5,
    parameter logic [THR_W-1:0] DEF_AL_FULL  = 5'd5,
    parameter logic [THR_W-1:0] DEF_AL_EMPTY = 5'd1
) (
    input  logic                clk,
    input  logic                RESET_L,
    input  logic                init,
    input  logic [THR_W-1:0]    umbral_full,
    input  logic [THR_W-1:0]    umbral_empty,
    input  logic [3:0]          in_empty,
    input  logic [4*DATA_W-1:0] in_data,
    input  logic [3:0]          out_al_full,
    input  logic [7:0]          err_in,
    output logic [3:0]          in_rd,
    output logic [3:0]          out_wr,
    output logic [DATA_W-1:0]   out_data,
    output logic [THR_W-1:0]    al_full_cfg,
    output logic [THR_W-1:0]    al_empty_cfg,
    output logic [4:0]          state,
    output logic                err
);

    localparam logic [4:0] ST_RESET  = 5'b00001;
    localparam logic [4:0] ST_INIT   = 5'b00010;
    localparam logic [4:0] ST_IDLE   = 5'b00100;
    localparam logic [4:0] ST_ACTIVE = 5'b01000;
    localparam logic [4:0] ST_ERROR  = 5'b10000;

    logic [4:0] state_nxt;
    logic [1:0] rr_ptr;
    logic [3:0] eligible;
    logic       err_hit;
    logic       grant_ok;
    logic       grant_vld;
    logic [1:0] grant_idx;
    logic [1:0] cand;
    logic       granted;
    logic       s1_vld;
    logic [1:0] s1_lane;

    assign eligible = ~in_empty & ~out_al_full;
    assign err_hit  = (state != ST_RESET) && (err_in != '0);
    assign grant_ok = ((state == ST_IDLE) || (state == ST_ACTIVE)) && !init && !err_hit;

    // Round-robin search starting one past the last granted lane.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        cand      = rr_ptr;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = rr_ptr + 2'(i);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign in_rd   = (grant_ok && grant_vld) ? (4'b0001 << grant_idx) : 4'b0000;
    assign granted = |in_rd;

    // Next-state selection; an error report overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_INIT;
            ST_INIT:   state_nxt = init ? ST_INIT : ST_IDLE;
            ST_IDLE,
            ST_ACTIVE: begin
                if (init)         state_nxt = ST_INIT;
                else if (granted) state_nxt = ST_ACTIVE;
                else              state_nxt = ST_IDLE;
            end
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_RESET;
        endcase
        if (err_hit) state_nxt = ST_ERROR;
    end

    // State register and sticky error flag.
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state <= ST_RESET;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (err_hit) err <= 1'b1;
        end
    end

    // Round-robin pointer follows the last granted lane.
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L)     rr_ptr <= 2'd3;
        else if (granted) rr_ptr <= grant_idx;
    end

    // Threshold registers load whenever init is requested outside RESET/ERROR.
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            al_full_cfg  <= DEF_AL_FULL;
            al_empty_cfg <= DEF_AL_EMPTY;
        end else if (init && !err_hit &&
                     ((state == ST_INIT) || (state == ST_IDLE) || (state == ST_ACTIVE))) begin
            al_full_cfg  <= umbral_full;
            al_empty_cfg <= umbral_empty;
        end
    end

    // Two-stage pop-to-push pipeline: stage 1 waits for the FIFO to present
    // the popped word, stage 2 captures it and pushes to the matching lane.
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            s1_vld   <= 1'b0;
            s1_lane  <= 2'd0;
            out_wr   <= 4'b0000;
            out_data <= '0;
        end else if (err_hit || (state == ST_ERROR)) begin
            s1_vld <= 1'b0;
            out_wr <= 4'b0000;
        end else begin
            s1_vld  <= granted;
            s1_lane <= grant_idx;
            out_wr  <= s1_vld ? (4'b0001 << s1_lane) : 4'b0000;
            if (s1_vld) out_data <= in_data[s1_lane*DATA_W +: DATA_W];
        end
    end

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin scheduler that moves 6-bit words from four input FIFO lanes to four matching output FIFO lanes. It is one pop per cycle, with lane k always routed to output lane k. It also programs the almost-empty and almost-full thresholds of all eight FIFOs, and halts traffic when any FIFO reports an error. It sits between the ingress FIFO bank and the egress FIFO bank, and is the only driver of their `fifo_rd`, `fifo_wr` and threshold inputs.

## Interface
- `DATA_W`, 6: word width.
- `THR_W`, 5: threshold width.
- `DEF_AL_FULL`, 5'd5: almost-full threshold value after reset.
- `DEF_AL_EMPTY`, 5'd1: almost-empty threshold value after reset.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `RESET_L`  in  1: asynchronous, active-low reset.
- `init`  in  1: threshold-load request.
- `umbral_full`  in  5: almost-full threshold to load.
- `umbral_empty`  in  5: almost-empty threshold to load.
- `in_empty`  in  4: `fifo_empty` of input lanes 3..0.
- `in_data`  in  24: `data_out` of input lanes; lane k is in bits [6k+5:6k].
- `out_al_full`  in  4: `al_full` of output lanes 3..0.
- `err_in`  in  8: `err_fifo` of all FIFOs (input lanes in [3:0], output lanes in [7:4]).
- `in_rd`  out  4: one-hot pop to input lanes. Combinational.
- `out_wr`  out  4: one-hot push to output lanes. Registered.
- `out_data`  out  6: word for `out_wr`. Registered.
- `al_full_cfg`  out  5: almost-full threshold broadcast to all FIFOs. Registered.
- `al_empty_cfg`  out  5: almost-empty threshold broadcast to all FIFOs. Registered.
- `state`  out  5: one-hot FSM state.
- `err`  out  1: sticky error flag.

## Operation
- **States** (one-hot): RESET = 00001, INIT = 00010, IDLE = 00100, ACTIVE = 01000, ERROR = 10000.
- **Reset values** (`RESET_L` = 0):
  - `state` = RESET; `err` = 0; RR pointer = 3, so lane 0 has first priority.
  - `in_rd` = 0, `out_wr` = 0, `out_data` = 0.
  - Pipeline valid bits cleared.
  - `al_full_cfg` = `DEF_AL_FULL`, `al_empty_cfg` = `DEF_AL_EMPTY`.
- **RESET → INIT**: on the first edge after `RESET_L` rises.
- **INIT**:
  - While `init` = 1, `umbral_full` and `umbral_empty` are loaded into the cfg registers every edge.
  - When `init` = 0, go to IDLE on the next edge; cfg keeps its last value (defaults if `init` never rose).
- **Eligibility**: lane k is eligible when `in_empty[k]` = 0 and `out_al_full[k]` = 0.
- **Grant** (IDLE or ACTIVE):
  - Grant the first eligible lane at pointer+1, pointer+2, ... modulo 4.
  - `in_rd[grant]` = 1 in the same cycle.
  - The pointer updates to the granted lane on the edge; no grant leaves the pointer unchanged.
- **IDLE / ACTIVE**: next state is ACTIVE if a grant was issued this cycle, else IDLE.
- **`init` = 1 in IDLE or ACTIVE**:
  - No grant this cycle; next state is INIT.
  - Words already in the pipeline still complete.
- **ERROR**:
  - Entered from any non-RESET state on the edge where `err_in` ≠ 0. This takes priority over all other transitions.
  - `err` = 1. `in_rd` is forced to 0 immediately.
  - `out_wr` goes to 0 from the next cycle, and in-flight words are discarded.
  - Only `RESET_L` exits ERROR.
- **Routing**: a word popped from lane k is written only to output lane k; its data is unmodified.

## Timing
- **Pop-to-push pipeline**:
  - Cycle t: `in_rd[k]` = 1; the input FIFO pops on edge t+1 and presents the word during cycle t+1.
  - Edge t+2: the arbiter captures `in_data` lane k.
  - Cycle t+2: `out_wr[k]` = 1 and `out_data` = word.
  - Edge t+3: the output FIFO stores the word.
- **Latency**: 2 cycles from `in_rd` to `out_wr`. Throughput is 1 word per cycle, sustained across lanes or on a single lane.
- **Back-to-back pops**: a lane with one word left raises `in_empty` after its pop edge, so there is no double pop.
- **Almost-full margin**: up to 2 grants can be in flight when `out_al_full` rises, so the output FIFO almost-full threshold must leave ≥3 free entries.
- **`init` response**: `init` going high during cycle t suppresses the grant in cycle t.
- **Threshold timing**: a value loaded on edge e is visible on `al_*_cfg` from cycle e.
- **Mid-operation reset**: asserting `RESET_L` = 0 at any time clears outputs asynchronously; in-flight words are lost.

## Test plan
- **Reset defaults**: hold `RESET_L` = 0, then release with `init` = 0.
  - Required: `state` goes 00001 → 00010 → 00100; `al_full_cfg` = 5, `al_empty_cfg` = 1; `in_rd` = 0 throughout.
- **Threshold load**: pulse `init` = 1 with `umbral_full` = 12, `umbral_empty` = 3.
  - Required: cfg = 12/3 from the next cycle; IDLE one cycle after `init` falls.
- **Round robin**: all four lanes non-empty, lane 1 preloaded with 0x15.
  - Required: `in_rd` = 0001, 0010, 0100, 1000, 0001, ...
  - Required: `out_wr` = 0010 with `out_data` = 0x15 exactly 2 cycles after the lane 1 pop.
- **Back-pressure**: `out_al_full` = 0100 while all lanes have data.
  - Required: lane 2 is skipped (`in_rd` = 0001, 0010, 1000 repeating).
  - Required: lane 2 resumes the cycle after `out_al_full[2]` drops.
- **Empty and single lane**: only lane 3 has 2 words.
  - Required: `in_rd` = 1000 for 2 consecutive cycles, then 0; `state` goes ACTIVE then IDLE; exactly 2 `out_wr` = 1000 pulses.
- **Error**: `err_in` = 00010000 mid-stream.
  - Required: `in_rd` = 0 in the same cycle; `state` = 10000 and `err` = 1 next cycle; no further `out_wr`.
  - Required: only `RESET_L` = 0 clears `err`.
